// File: rtl/seq_div_32b.sv
// seq_div_32b: iterative unsigned restoring divider, one quotient bit per clock
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   start       request, accepted only in IDLE or DONE
//   dividend    unsigned dividend, captured on accepted start
//   divisor     unsigned divisor, captured on accepted start
//   busy        high while iterating
//   done        one-cycle pulse when results become valid
//   quotient    registered quotient ({WIDTH{1}} on divide by zero)
//   remainder   registered remainder (dividend on divide by zero)
//   div_by_zero registered flag, held until the next accepted start
module seq_div_32b #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] q_sr, dvs, p, d_lo, p_nx, q_nx;
  logic [WIDTH:0] p_sh;
  logic [CNT_W-1:0] cnt;
  logic carry, no_borrow, last;
  // The shifted partial remainder is 33 bits; its top bit set means it already
  // exceeds any 32-bit divisor, so no borrow regardless of the low subtract.
  always_comb begin
    p_sh = {p, q_sr[WIDTH-1]};
    {carry, d_lo} = {1'b0, p_sh[WIDTH-1:0]} + {1'b0, ~dvs} + (WIDTH+1)'(1);
    no_borrow = p_sh[WIDTH] | carry;
    p_nx = no_borrow ? d_lo : p_sh[WIDTH-1:0];
    q_nx = {q_sr[WIDTH-2:0], no_borrow};
    last = cnt == CNT_W'(WIDTH-1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
      q_sr <= '0;
      dvs <= '0;
      p <= '0;
      cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          q_sr <= q_nx;
          p <= p_nx;
          cnt <= cnt + 1'b1;
          if (last) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
            quotient <= q_nx;
            remainder <= p_nx;
          end
        end
        IDLE, DONE: begin
          if (start && divisor == '0) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
            quotient <= '1;
            remainder <= dividend;
            div_by_zero <= 1'b1;
          end else if (start) begin
            state <= RUN;
            busy <= 1'b1;
            done <= 1'b0;
            q_sr <= dividend;
            dvs <= divisor;
            p <= '0;
            cnt <= '0;
            div_by_zero <= 1'b0;
          end else begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
          done <= 1'b0;
        end
      endcase
    end
  end
endmodule
